sram_word_splitter: RTL and testbench

- Sits directly upstream of the external 16-bit SRAM front-end.
- Accepts one 32-bit CPU memory request at a time on a valid/ready handshake.
- Issues it to the SRAM as two sequential 16-bit accesses: low half first, then high half.
- Returns a single 32-bit response pulse; for reads, the two halves are reassembled.

---
 rtl/sram_word_splitter_pkg.sv | 14 +
 rtl/sram_word_splitter.sv | 111 +++++++++++
 tb/tb_sram_word_splitter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_word_splitter_pkg.sv
// sram_word_splitter_pkg: shared frontend state encodings and SRAM access timing
package sram_word_splitter_pkg;

    localparam int SPLIT_SRAM_CYC = 3;

    typedef enum logic [2:0] {
        SPLIT_IDLE = 3'd0,
        SPLIT_LO   = 3'd1,
        SPLIT_GAP  = 3'd2,
        SPLIT_HI   = 3'd3,
        SPLIT_RESP = 3'd4
    } split_state_t;

endpackage

// File: rtl/sram_word_splitter.sv
// sram_word_splitter: issues one 32-bit CPU request as two 16-bit SRAM accesses
module sram_word_splitter
    import sram_word_splitter_pkg::*;
#(
    parameter int SRAM_CYC = SPLIT_SRAM_CYC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        sram_valid,
    output logic        sram_rw,
    output logic [31:0] sram_addr,
    output logic [15:0] sram_dtw,
    input  logic [15:0] sram_din
);

    localparam int CW = $clog2(SRAM_CYC + 1);

    split_state_t  state;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic [29:0]   word_q;
    logic [31:0]   wdata_q;
    logic [15:0]   rdata_lo;
    logic          cnt_last;
    logic          unused_addr_lsbs;

    assign cnt_last         = cnt == CW'(SRAM_CYC - 1);
    assign unused_addr_lsbs = ^req_addr[1:0];

    // Sequencer: latches the request, drives low then high halfword access, reassembles reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= SPLIT_IDLE;
            cnt        <= '0;
            rw_q       <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_lo   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            sram_valid <= 1'b0;
            sram_rw    <= 1'b0;
            sram_addr  <= '0;
            sram_dtw   <= '0;
        end else begin
            case (state)
                SPLIT_IDLE: if (req_valid) begin
                    state      <= SPLIT_LO;
                    req_ready  <= 1'b0;
                    rw_q       <= req_rw;
                    word_q     <= req_addr[31:2];
                    wdata_q    <= req_wdata;
                    cnt        <= '0;
                    sram_valid <= 1'b1;
                    sram_rw    <= req_rw;
                    sram_addr  <= {1'b0, req_addr[31:2], 1'b0};
                    sram_dtw   <= req_wdata[15:0];
                end
                SPLIT_LO: if (cnt_last) begin
                    if (!rw_q) rdata_lo <= sram_din;
                    state      <= SPLIT_GAP;
                    sram_valid <= 1'b0;
                    sram_rw    <= 1'b0;
                    sram_addr  <= '0;
                    sram_dtw   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                SPLIT_GAP: begin
                    state      <= SPLIT_HI;
                    cnt        <= '0;
                    sram_valid <= 1'b1;
                    sram_rw    <= rw_q;
                    sram_addr  <= {1'b0, word_q, 1'b1};
                    sram_dtw   <= wdata_q[31:16];
                end
                SPLIT_HI: if (cnt_last) begin
                    state      <= SPLIT_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= rw_q ? 32'd0 : {sram_din, rdata_lo};
                    sram_valid <= 1'b0;
                    sram_rw    <= 1'b0;
                    sram_addr  <= '0;
                    sram_dtw   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                SPLIT_RESP: begin
                    state      <= SPLIT_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= SPLIT_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    sram_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_word_splitter.sv
// tb_sram_word_splitter: randomized scoreboard bench with a halfword-memory reference model
module tb_sram_word_splitter;
    import sram_word_splitter_pkg::*;

    localparam int CYC = SPLIT_SRAM_CYC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        sram_valid;
    logic        sram_rw;
    logic [31:0] sram_addr;
    logic [15:0] sram_dtw;
    logic [15:0] sram_din;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { logic [31:0] data; int due; } resp_t;
    typedef struct { logic rw; logic [31:0] addr; logic [15:0] dtw; int due; } acc_t;

    resp_t exp_resp[$];
    acc_t  exp_acc[$];
    logic [15:0] mem [logic [31:0]];
    acc_t  cur;
    resp_t r;
    int    blen = 0;
    logic  prev_sv = 1'b0;
    logic [31:0] last_rdata = '0;

    sram_word_splitter dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_valid(sram_valid), .sram_rw(sram_rw), .sram_addr(sram_addr),
        .sram_dtw(sram_dtw), .sram_din(sram_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'hA5C3);
    endfunction

    // Monitor and SRAM model: checks every cycle, returns read data only on the last access cycle
    always @(negedge clk) begin
        if (!rstn) begin
            exp_resp.delete();
            exp_acc.delete();
            blen = 0;
            prev_sv = 1'b0;
            last_rdata = '0;
            sram_din = '0;
        end else begin
            if (sram_valid) begin
                if (!prev_sv) begin
                    if (exp_acc.size() == 0) begin
                        check("sram_valid_unexpected", sram_valid, 0);
                        cur = '{rw: sram_rw, addr: sram_addr, dtw: sram_dtw, due: cyc};
                    end else begin
                        cur = exp_acc.pop_front();
                        check("sram_start_cycle", cyc, cur.due);
                    end
                end
                check("sram_rw", sram_rw, cur.rw);
                check("sram_addr", sram_addr, cur.addr);
                check("sram_dtw", sram_dtw, cur.dtw);
            end else begin
                if (prev_sv) check("sram_burst_len", blen, CYC);
                check("idle_sram_bus", {sram_rw, sram_dtw, sram_addr}, 0);
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    check("resp_valid_unexpected", resp_valid, 0);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_cycle", cyc, r.due);
                    check("resp_rdata", resp_rdata, r.data);
                end
                last_rdata = resp_rdata;
            end else begin
                check("resp_rdata_hold", resp_rdata, last_rdata);
            end
            check("req_ready", req_ready, exp_resp.size() == 0 && !resp_valid);
            blen = sram_valid ? blen + 1 : 0;
            sram_din = (sram_valid && !sram_rw && blen == CYC) ? mem_rd(sram_addr) : 16'($urandom);
            prev_sv = sram_valid;
        end
    end

    // Presents one request from a falling edge, waits for acceptance, records the expected traffic
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit keep, input bit commit, output int acc);
        int n = 0;
        logic [31:0] lo;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        acc = -1;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 4 * CYC + 20) begin
                check("accept_timeout", req_ready, 1);
                req_valid = 1'b0;
                return;
            end
        end
        acc = cyc;
        @(posedge clk);
        lo = (addr >> 2) * 2;
        exp_acc.push_back('{rw: rw, addr: lo, dtw: wdata[15:0], due: acc + 1});
        exp_acc.push_back('{rw: rw, addr: lo + 1, dtw: wdata[31:16], due: acc + CYC + 2});
        exp_resp.push_back('{data: rw ? 32'd0 : {mem_rd(lo + 1), mem_rd(lo)}, due: acc + 2 * CYC + 2});
        if (rw && commit) begin
            mem[lo]     = wdata[15:0];
            mem[lo + 1] = wdata[31:16];
        end
        @(negedge clk);
        if (!keep) begin
            req_valid = 1'b0;
            req_rw    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a1, a2;
        logic [31:0] pool [4];
        pool[0] = 32'h10; pool[1] = 32'h20; pool[2] = 32'hFFFF_FFFC; pool[3] = 32'h0000_1000;
        mem[32'h8] = 16'hBEEF;
        mem[32'h9] = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_outputs", {sram_valid, sram_rw, sram_addr, sram_dtw, resp_valid}, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        #2 rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_sram_valid", sram_valid, 0);

        issue(1'b0, 32'h0000_0010, 32'hCAFE_F00D, 0, 1, a1);
        issue(1'b1, 32'h0000_0023, 32'h1234_5678, 0, 1, a1);
        issue(1'b0, 32'h0000_0020, 32'h0, 0, 1, a1);
        issue(1'b0, 32'hFFFF_FFFC, 32'h5555_AAAA, 0, 1, a1);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0, 1, a1);
        issue(1'b0, 32'hFFFF_FFFD, 32'h0, 0, 1, a1);

        issue(1'b0, 32'h0000_0010, 32'h0, 1, 1, a1);
        issue(1'b0, 32'h0000_0020, 32'h0, 0, 1, a2);
        check("back_to_back_accept_gap", a2 - a1, 2 * CYC + 3);
        repeat (2 * CYC + 4) @(negedge clk);

        issue(1'b1, 32'h0000_0100, 32'h7777_8888, 0, 0, a1);
        repeat (5) @(negedge clk);
        check("abort_mid_hi_sram_valid", sram_valid, 1);
        #1 rstn = 1'b0;
        #1;
        check("abort_sram_valid_async", sram_valid, 0);
        check("abort_req_ready_async", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (3 * CYC + 6) @(negedge clk);
        check("post_abort_req_ready", req_ready, 1);
        issue(1'b0, 32'h0000_0100, 32'h0, 0, 1, a1);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom), ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom,
                  $urandom, 0, 1, a1);
        end

        repeat (2 * CYC + 6) @(negedge clk);
        check("drained_responses", exp_resp.size(), 0);
        check("drained_accesses", exp_acc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
